// File: rtl/psram_responder_if.sv
// Control, address and status bundle between mem_control and psram_responder.
// The shared 16-bit data bus stays a plain inout on the responder itself.
interface psram_responder_if;
  logic [25:0] addr;
  logic        memclk;
  logic        adv_n;
  logic        cre;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic        lb_n;
  logic        ub_n;
  logic        rd_active;
  logic        wr_strobe;

  modport master (
    output addr, memclk, adv_n, cre, ce_n, oe_n, we_n, lb_n, ub_n,
    input  rd_active, wr_strobe
  );

  modport slave (
    input  addr, memclk, adv_n, cre, ce_n, oe_n, we_n, lb_n, ub_n,
    output rd_active, wr_strobe
  );
endinterface

// File: rtl/psram_responder.sv
// Asynchronous-mode Cellular RAM stand-in: registered pin sampling, 16-bit word array,
// byte-lane writes and fixed-latency reads. Define PSRAM_BCR_EN to add the BCR on cre=1.
module psram_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned READ_LAT   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  psram_responder_if.slave bus,
  inout  wire  [15:0]      mem_data
);

  localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  LatFull = 4'(READ_LAT);
  localparam logic [3:0]  LatM1   = 4'(READ_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdDrive, StWrite} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [25:0] addr_lat_q, addr_lat_d;
  logic        addr_change;
  logic        commit;
  logic        capture;
  logic        mem_we;
  logic        wr_strobe_q;
  logic [15:0] rd_word;
  logic        drive_lo, drive_hi;

  logic [25:0] addr_q;
  logic        adv_n_q, cre_q, ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
  logic [15:0] data_q;

  logic [15:0] wdata_q;
  logic [1:0]  wbe_q;
  logic [25:0] waddr_q;

  logic [15:0] mem [Depth];

  // Single input register stage; reset values look like an idle, deselected bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q  <= '0;
      adv_n_q <= 1'b1;
      cre_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      addr_q  <= bus.addr;
      adv_n_q <= bus.adv_n;
      cre_q   <= bus.cre;
      ce_n_q  <= bus.ce_n;
      oe_n_q  <= bus.oe_n;
      we_n_q  <= bus.we_n;
      lb_n_q  <= bus.lb_n;
      ub_n_q  <= bus.ub_n;
      data_q  <= mem_data;
    end
  end

  assign addr_lat_d  = adv_n_q ? addr_lat_q : addr_q;
  assign addr_change = (addr_lat_d != addr_lat_q);

  // cnt_q holds the cycles left in StRdWait. A fresh read spends READ_LAT-1 cycles there
  // (none when READ_LAT is 1); an address change inside a read spends READ_LAT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!ce_n_q) begin
          if (!we_n_q) begin
            state_d = StWrite;
          end else if (!oe_n_q) begin
            if (READ_LAT <= 1) begin
              state_d = StRdDrive;
            end else begin
              state_d = StRdWait;
              cnt_d   = LatM1;
            end
          end
        end
      end
      StRdWait, StRdDrive: begin
        if (ce_n_q) begin
          state_d = StIdle;
        end else if (!we_n_q) begin
          state_d = StWrite;
        end else if (oe_n_q) begin
          state_d = StIdle;
        end else if (addr_change) begin
          state_d = StRdWait;
          cnt_d   = LatFull;
        end else if (state_q == StRdWait) begin
          if (cnt_q <= 4'd1) begin
            state_d = StRdDrive;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StWrite: begin
        if (we_n_q || ce_n_q) begin
          state_d = StIdle;
          commit  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Data, address and lanes are frozen from the last cycle we_n was still sampled low.
  assign capture = (state_d == StWrite);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_lat_q  <= '0;
      wr_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lat_q  <= addr_lat_d;
      wr_strobe_q <= commit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdata_q <= '0;
      wbe_q   <= '0;
      waddr_q <= '0;
    end else if (capture) begin
      wdata_q <= data_q;
      wbe_q   <= {~ub_n_q, ~lb_n_q};
      waddr_q <= addr_lat_d;
    end
  end

`ifdef PSRAM_BCR_EN
  logic        wcre_q;
  logic [15:0] bcr_q;
  logic        unused_sig;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wcre_q <= 1'b0;
    end else if (capture) begin
      wcre_q <= cre_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bcr_q <= 16'h9D1F;
    end else if (commit && wcre_q) begin
      bcr_q <= waddr_q[15:0];
    end
  end

  assign mem_we     = commit && !wcre_q && reset_n;
  assign rd_word    = cre_q ? bcr_q : mem[addr_lat_q[DEPTH_LOG2-1:0]];
  assign unused_sig = ^{bus.memclk, waddr_q};
`else
  logic unused_sig;

  assign mem_we     = commit && reset_n;
  assign rd_word    = mem[addr_lat_q[DEPTH_LOG2-1:0]];
  assign unused_sig = ^{bus.memclk, cre_q, waddr_q};
`endif

  // Array contents survive reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (wbe_q[0]) begin
        mem[waddr_q[DEPTH_LOG2-1:0]][7:0] <= wdata_q[7:0];
      end
      if (wbe_q[1]) begin
        mem[waddr_q[DEPTH_LOG2-1:0]][15:8] <= wdata_q[15:8];
      end
    end
  end

  assign drive_lo = (state_q == StRdDrive) && !lb_n_q;
  assign drive_hi = (state_q == StRdDrive) && !ub_n_q;

  assign mem_data[7:0]  = drive_lo ? rd_word[7:0]  : 8'hzz;
  assign mem_data[15:8] = drive_hi ? rd_word[15:8] : 8'hzz;

  assign bus.rd_active = (state_q == StRdDrive);
  assign bus.wr_strobe = wr_strobe_q;

endmodule

// File: doc/psram_responder.md
# psram_responder

Single-clock responder for the asynchronous Cellular RAM (PSRAM) interface driven by `mem_control`. It samples the chip-select, strobe, byte-enable and address lines, stores 16-bit words in an internal array, and drives `mem_data` back on reads after a programmable latency. It stands in for the board PSRAM in simulation and in on-chip loopback builds, so `mem_control` can be exercised without external memory.

## Interface
Parameters:
- `DEPTH_LOG2`, 8: array holds 2^DEPTH_LOG2 words of 16 bits; only `addr[DEPTH_LOG2-1:0]` is decoded.
- `READ_LAT`, 2: clocks from the sampled read request to data on the bus; legal range 1–15.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: sole clock, same 10 MHz domain as `mem_control`.
- `reset_n` input 1: synchronous active-low reset.
- `addr` input 26: word address from the controller.
- `memclk` input 1: ignored (asynchronous mode only).
- `adv_n` input 1: address-valid strobe, active low.
- `cre` input 1: configuration-register enable.
- `ce_n` `oe_n` `we_n` input 1 each: chip enable, output enable and write enable, all active low.
- `lb_n` `ub_n` input 1 each: lower/upper byte enables, active low.
- `mem_data` inout 16: shared data bus.
- `rd_active` output 1: high while the responder drives `mem_data`.
- `wr_strobe` output 1: one-clock pulse when a write commits.

## Operation
- All inputs are registered once on `posedge clk`. Every decision uses these sampled values.
- Address latch: the sampled `addr` is captured only while `adv_n`=0. While `adv_n`=1, the last latched address is held.
- States:
  - IDLE: waits for a request.
    - `ce_n`=0 and `we_n`=0 goes to WRITE. Write takes priority over `oe_n`.
    - `ce_n`=0, `we_n`=1 and `oe_n`=0 goes to RD_WAIT and loads the latency counter with `READ_LAT`-1.
  - RD_WAIT: counts down to 0, then goes to RD_DRIVE.
  - RD_DRIVE: drives `array[addr]` onto `mem_data`.
    - A byte lane with its enable high is high-Z.
    - A change in the latched address returns to RD_WAIT with the bus released.
  - Leaving a read: sampled `ce_n`=1 or `oe_n`=1 in RD_WAIT or RD_DRIVE returns to IDLE. The bus is released at that edge.
  - WRITE:
    - Each cycle, holds the last sampled data, address and byte enables.
    - On the edge that samples `we_n`=1 or `ce_n`=1, writes the enabled bytes, pulses `wr_strobe`, and returns to IDLE.
    - Disabled lanes keep their old contents.
- During WRITE, the bus is never driven. A sampled `we_n`=0 in RD_WAIT or RD_DRIVE aborts the read, releases the bus and enters WRITE.
- Address aliasing: addresses above the array depth alias onto the decoded low bits. No error is flagged.

## Timing
- Reset values:
  - state IDLE
  - `mem_data` all high-Z
  - `rd_active`=0, `wr_strobe`=0
  - latched address 0
  - BCR 16'h9D1F (when compiled in)
  - Array contents are not cleared.
- Read latency: pins asserted at edge N are sampled at N+1. Data is valid and `rd_active`=1 after edge N+1+`READ_LAT`.
- Write latency: `we_n` deasserted before edge M is sampled at M. The array updates and `wr_strobe` pulses after edge M+1. A read of the same address issued afterwards returns the new data.
- Bus release: `mem_data` goes high-Z one clock after the `oe_n`/`ce_n` deassertion edge.
- Reset: `reset_n`=0 mid-read or mid-write forces IDLE and releases the bus at the same edge. An uncommitted write is discarded.
- `ce_n`=1 overrides everything else.

## Configuration
- `PSRAM_BCR_EN` defined: `cre`=1 redirects the cycle to the 16-bit bus configuration register (BCR).
  - A write cycle loads BCR from the latched `addr[15:0]`. The array is untouched and `wr_strobe` still pulses.
  - A read cycle returns BCR with the same latency.
- `PSRAM_BCR_EN` undefined: `cre` is ignored and every cycle accesses the array. No BCR flops exist.

## Test plan
- Reset, then pins idle → `mem_data`=Z, `rd_active`=0, `wr_strobe`=0.
- Write 16'hA55A to address 3 with both lanes enabled, then read address 3 → 16'hA55A appears `READ_LAT`+1 clocks after `oe_n` falls; exactly one `wr_strobe` pulse.
- Write 16'h1234 to address 5 with `ub_n`=1, over old contents 16'hFFFF, then read → 16'hFF34. During a read with `lb_n`=1, `mem_data[7:0]`=Z.
- Change the address from 3 to 4 while `oe_n` stays low → bus goes Z, then shows `array[4]` after `READ_LAT` clocks. Access address 2^DEPTH_LOG2+3 → returns `array[3]`.
- `reset_n`=0 in the middle of a write, with `we_n` still low → no `wr_strobe`, array unchanged, bus Z.
- With `PSRAM_BCR_EN` defined: `cre`=1 write with addr 16'h0010, then `cre`=1 read → 16'h0010; array word 16'h0010 unchanged. Without the macro, the same sequence writes the array.
